// File: rtl/board_io_pkg.sv
// Shared types and elaboration-time helpers for the board input conditioner.
package board_io_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    COUNT     = 2'd1,
    RUN       = 2'd2
  } rst_state_t;

  // Bits needed for a counter with n distinct values (never less than 1).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Prescaler period in clk cycles per debounce tick.
  function automatic int unsigned tick_period(input int unsigned clock_freq,
                                              input int unsigned tick_hz);
    return clock_freq / tick_hz;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchroniser, polarity correction, tick-counted
// debounce and registered one-cycle edge pulses.
module debounce_channel
  import board_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 5,
  parameter bit          INVERT         = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned    CW   = cnt_width(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_TICKS - 1);

  logic          sync_meta_q, sync_q;
  logic          cond;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Sync flops reset to the idle pad level so cond is 0 out of reset.
  assign cond = sync_q ^ INVERT;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (cond == stable_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == LAST) begin
        stable_d = cond;
        cnt_d    = '0;
        rise_d   = cond;
        fall_d   = ~cond;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta_q <= INVERT;
      sync_q      <= INVERT;
      cnt_q       <= '0;
      stable_q    <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values; the synchroniser depends on it.
      sync_meta_q <= raw_i;
      sync_q      <= sync_meta_q;
      cnt_q       <= cnt_d;
      stable_q    <= stable_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

endmodule

// File: rtl/board_io_conditioner.sv
// Board input conditioning: lock-qualified POR sequencer for the core reset,
// shared debounce prescaler and NUM_INPUTS debounced input channels.
module board_io_conditioner
  import board_io_pkg::*;
#(
  parameter int unsigned           CLOCK_FREQ     = 25125000,
  parameter int unsigned           TICK_HZ        = 1000,
  parameter int unsigned           DEBOUNCE_TICKS = 5,
  parameter int unsigned           POR_CYCLES     = 10000,
  parameter int unsigned           NUM_INPUTS     = 8,
  parameter logic [NUM_INPUTS-1:0] INVERT_MASK    = '0
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  PLL_LOCKED,
  input  logic [NUM_INPUTS-1:0] RAW_IN,
  output logic                  RSTb_OUT,
  output logic [NUM_INPUTS-1:0] IN_STABLE,
  output logic [NUM_INPUTS-1:0] IN_RISE,
  output logic [NUM_INPUTS-1:0] IN_FALL
);

  localparam int unsigned P  = tick_period(CLOCK_FREQ, TICK_HZ);
  localparam int unsigned PW = cnt_width(P);
  localparam int unsigned RW = cnt_width(POR_CYCLES);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  logic          lock_meta_q, lock_s_q;
  rst_state_t    state_q, state_d;
  logic [RW-1:0] por_cnt_q, por_cnt_d;
  logic          rstb_q;

  assign tick    = (presc_q == PW'(P - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    por_cnt_d = por_cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        por_cnt_d = '0;
        if (lock_s_q) state_d = COUNT;
      end
      COUNT: begin
        if (!lock_s_q) begin
          state_d   = WAIT_LOCK;
          por_cnt_d = '0;
        end else if (por_cnt_q == RW'(POR_CYCLES - 1)) begin
          state_d   = RUN;
          por_cnt_d = '0;
        end else begin
          por_cnt_d = por_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s_q) state_d = WAIT_LOCK;
      end
      default: begin
        state_d   = WAIT_LOCK;
        por_cnt_d = '0;
      end
    endcase
  end

  // Core reset is registered from the next state so it releases on entry to RUN.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      presc_q     <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= WAIT_LOCK;
      por_cnt_q   <= '0;
      rstb_q      <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      lock_meta_q <= PLL_LOCKED;
      lock_s_q    <= lock_meta_q;
      state_q     <= state_d;
      por_cnt_q   <= por_cnt_d;
      rstb_q      <= (state_d == RUN);
    end
  end

  assign RSTb_OUT = rstb_q;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .INVERT        (INVERT_MASK[i])
    ) u_ch (
      .clk     (clk),
      .rst     (RST),
      .tick_i  (tick),
      .raw_i   (RAW_IN[i]),
      .stable_o(IN_STABLE[i]),
      .rise_o  (IN_RISE[i]),
      .fall_o  (IN_FALL[i])
    );
  end

endmodule

// File: tb/tb_board_io_conditioner.sv
// Self-checking bench for board_io_conditioner: directed scenarios plus random
// pad/lock activity compared each cycle against a window/tick-count model.
module tb_board_io_conditioner;

  localparam int         CLOCK_FREQ = 1000;
  localparam int         TICK_HZ    = 100;
  localparam int         DT         = 3;
  localparam int         POR        = 16;
  localparam int         NI         = 8;
  localparam logic [7:0] MASK       = 8'h0F;
  localparam int         P          = CLOCK_FREQ / TICK_HZ;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pll = 1'b0;
  logic [7:0] raw = MASK;
  logic       rstb;
  logic [7:0] stable, rise, fall;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state. cyc counts clk edges since reset release.
  int         cyc;
  logic [7:0] raw_hist[$];
  bit         lock_hist[$];
  int         lock_run;
  logic       m_rstb;
  logic [7:0] m_stable, m_rise, m_fall;
  int         m_start[NI];

  board_io_conditioner #(
    .CLOCK_FREQ    (CLOCK_FREQ),
    .TICK_HZ       (TICK_HZ),
    .DEBOUNCE_TICKS(DT),
    .POR_CYCLES    (POR),
    .NUM_INPUTS    (NI),
    .INVERT_MASK   (MASK)
  ) dut (
    .clk       (clk),
    .RST       (rst),
    .PLL_LOCKED(pll),
    .RAW_IN    (raw),
    .RSTb_OUT  (rstb),
    .IN_STABLE (stable),
    .IN_RISE   (rise),
    .IN_FALL   (fall)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    cyc = 0;
    raw_hist.delete();
    lock_hist.delete();
    lock_run = 0;
    m_rstb   = 1'b0;
    m_stable = '0;
    m_rise   = '0;
    m_fall   = '0;
    for (int i = 0; i < NI; i++) m_start[i] = 0;
  endtask

  // Ticks seen (including the current edge) since channel i began to disagree.
  function automatic int ticks_acc(input int i);
    return (m_start[i] == 0) ? 0 : (cyc / P) - ((m_start[i] - 1) / P);
  endfunction

  // Advance one clk edge, update the model, return 1 time unit after the edge.
  // The core reset is high once lock has been seen for POR+1 consecutive edges;
  // a channel accepts a new level on the tick that makes DT ticks of disagreement.
  task automatic clk_step();
    logic [7:0] raw_now, cond;
    bit         lk_now, lock_s;
    raw_now = raw;
    lk_now  = pll;
    @(posedge clk);
    cyc++;
    cond   = (raw_hist.size() >= 2) ? (raw_hist[0] ^ MASK) : 8'h00;
    lock_s = (lock_hist.size() >= 2) ? lock_hist[0] : 1'b0;
    raw_hist.push_back(raw_now);
    lock_hist.push_back(lk_now);
    if (raw_hist.size() > 2) void'(raw_hist.pop_front());
    if (lock_hist.size() > 2) void'(lock_hist.pop_front());
    lock_run = lock_s ? lock_run + 1 : 0;
    m_rstb   = (lock_run >= POR + 1);
    m_rise   = '0;
    m_fall   = '0;
    for (int i = 0; i < NI; i++) begin
      if (cond[i] == m_stable[i]) begin
        m_start[i] = 0;
      end else begin
        if (m_start[i] == 0) m_start[i] = cyc;
        if ((cyc % P == 0) && (ticks_acc(i) == DT)) begin
          m_stable[i] = cond[i];
          m_rise[i]   = cond[i];
          m_fall[i]   = ~cond[i];
          m_start[i]  = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    pll = 1'b1;
    raw = MASK;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({rstb, stable, rise, fall} !== 25'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0", {rstb, stable, rise, fall});
    end
  endtask

  task automatic test_power_on();
    #2 rst = 1'b0;
    model_reset();
    for (int k = 0; k < 25; k++) begin
      clk_step();
      n_checks++;
      if ({rstb, stable, rise, fall} !== {m_rstb, m_stable, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL power_on cyc=%0d: got %h want %h", cyc,
                 {rstb, stable, rise, fall}, {m_rstb, m_stable, m_rise, m_fall});
      end
      if (cyc == 18 || cyc == 19) begin
        n_checks++;
        if (rstb !== (cyc == 19)) begin
          n_fail++;
          $display("FAIL por_edge cyc=%0d: got %b want %b", cyc, rstb, cyc == 19);
        end
      end
    end
  endtask

  task automatic test_lock_loss();
    int rise_at;
    pll = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      clk_step();
      n_checks++;
      if ({rstb, stable, rise, fall} !== {m_rstb, m_stable, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL lock_loss_run k=%0d: got %h want %h", k,
                 {rstb, stable, rise, fall}, {m_rstb, m_stable, m_rise, m_fall});
      end
      if (k == 2 || k == 3) begin
        n_checks++;
        if (rstb !== (k == 2)) begin
          n_fail++;
          $display("FAIL lock_fall_edge k=%0d: got %b want %b", k, rstb, k == 2);
        end
      end
    end
    pll = 1'b1;
    for (int k = 0; k < 8; k++) clk_step();
    pll = 1'b0;
    for (int k = 0; k < 6; k++) begin
      clk_step();
      n_checks++;
      if ({rstb, stable, rise, fall} !== {m_rstb, m_stable, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL lock_loss_count k=%0d: got %h want %h", k,
                 {rstb, stable, rise, fall}, {m_rstb, m_stable, m_rise, m_fall});
      end
    end
    pll = 1'b1;
    rise_at = -1;
    for (int k = 1; k <= 25; k++) begin
      clk_step();
      if (rstb === 1'b1 && rise_at < 0) rise_at = k;
      n_checks++;
      if ({rstb, stable, rise, fall} !== {m_rstb, m_stable, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL relock k=%0d: got %h want %h", k,
                 {rstb, stable, rise, fall}, {m_rstb, m_stable, m_rise, m_fall});
      end
    end
    n_checks++;
    if (rise_at != 19) begin
      n_fail++;
      $display("FAIL relock_latency: got %0d edges want 19", rise_at);
    end
  endtask

  task automatic test_press();
    int lat, n_rise, n_fall;
    raw[4] = 1'b1;
    lat    = -1;
    n_rise = 0;
    for (int k = 1; k <= 40; k++) begin
      clk_step();
      if (stable[4] === 1'b1 && lat < 0) lat = k;
      if (rise[4] === 1'b1) n_rise++;
      n_checks++;
      if ({rstb, stable, rise, fall} !== {m_rstb, m_stable, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL press k=%0d: got %h want %h", k,
                 {rstb, stable, rise, fall}, {m_rstb, m_stable, m_rise, m_fall});
      end
    end
    n_checks++;
    if (lat < 2 + (DT - 1) * P + 1 || lat > 2 + DT * P || n_rise != 1) begin
      n_fail++;
      $display("FAIL press_window: got latency %0d rises %0d want 23..32 and 1", lat, n_rise);
    end
    raw[4] = 1'b0;
    n_fall = 0;
    for (int k = 1; k <= 40; k++) begin
      clk_step();
      if (fall[4] === 1'b1) n_fall++;
      n_checks++;
      if ({rstb, stable, rise, fall} !== {m_rstb, m_stable, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL release k=%0d: got %h want %h", k,
                 {rstb, stable, rise, fall}, {m_rstb, m_stable, m_rise, m_fall});
      end
    end
    n_checks++;
    if (n_fall != 1 || stable[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL release_pulse: got falls %0d stable %b want 1 and 0", n_fall, stable[4]);
    end
  endtask

  task automatic test_bounce();
    int n_pulse, n_rise;
    n_pulse = 0;
    for (int k = 0; k < 100; k++) begin
      if (k % 7 == 0) raw[0] = ~raw[0];
      clk_step();
      if (rise[0] === 1'b1 || fall[0] === 1'b1) n_pulse++;
      n_checks++;
      if ({rstb, stable, rise, fall} !== {m_rstb, m_stable, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL bounce k=%0d: got %h want %h", k,
                 {rstb, stable, rise, fall}, {m_rstb, m_stable, m_rise, m_fall});
      end
    end
    n_checks++;
    if (n_pulse != 0) begin
      n_fail++;
      $display("FAIL bounce_quiet: got %0d pulses want 0", n_pulse);
    end
    raw[0] = 1'b0;
    n_rise = 0;
    for (int k = 0; k < 40; k++) begin
      clk_step();
      if (rise[0] === 1'b1) n_rise++;
      n_checks++;
      if ({rstb, stable, rise, fall} !== {m_rstb, m_stable, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL bounce_hold k=%0d: got %h want %h", k,
                 {rstb, stable, rise, fall}, {m_rstb, m_stable, m_rise, m_fall});
      end
    end
    n_checks++;
    if (n_rise != 1 || stable[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_accept: got rises %0d stable %b want 1 and 1", n_rise, stable[0]);
    end
  endtask

  task automatic test_simultaneous();
    int         n_events;
    logic [3:0] first_rise;
    repeat ($urandom_range(0, P - 1)) clk_step();
    raw[7:4]   = 4'hF;
    n_events   = 0;
    first_rise = '0;
    for (int k = 0; k < 40; k++) begin
      clk_step();
      if (rise[7:4] !== 4'h0) begin
        if (n_events == 0) first_rise = rise[7:4];
        n_events++;
      end
      n_checks++;
      if ({rstb, stable, rise, fall} !== {m_rstb, m_stable, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL simultaneous k=%0d: got %h want %h", k,
                 {rstb, stable, rise, fall}, {m_rstb, m_stable, m_rise, m_fall});
      end
    end
    n_checks++;
    if (n_events != 1 || first_rise !== 4'hF) begin
      n_fail++;
      $display("FAIL simultaneous_rise: got %0d events first %h want 1 event of f",
               n_events, first_rise);
    end
  endtask

  task automatic test_random();
    int idx;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 11) == 0) begin
        idx      = int'($urandom_range(0, NI - 1));
        raw[idx] = ~raw[idx];
      end
      if ($urandom_range(0, 299) == 0) pll = ~pll;
      clk_step();
      n_checks++;
      if ({rstb, stable, rise, fall} !== {m_rstb, m_stable, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL random k=%0d: got %h want %h", k,
                 {rstb, stable, rise, fall}, {m_rstb, m_stable, m_rise, m_fall});
      end
    end
  endtask

  task automatic test_reset_mid();
    int accept_at;
    pll = 1'b1;
    raw = MASK | 8'h10;
    for (int k = 0; k < 60; k++) clk_step();
    raw[1] = 1'b0;
    for (int k = 0; k < 40 && ticks_acc(1) != 2; k++) begin
      clk_step();
      n_checks++;
      if ({rstb, stable, rise, fall} !== {m_rstb, m_stable, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL mid_debounce k=%0d: got %h want %h", k,
                 {rstb, stable, rise, fall}, {m_rstb, m_stable, m_rise, m_fall});
      end
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({rstb, stable, rise, fall} !== 25'h0) begin
      n_fail++;
      $display("FAIL async_clear: got %h want 0", {rstb, stable, rise, fall});
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    accept_at = -1;
    for (int k = 0; k < 35; k++) begin
      clk_step();
      if (stable[1] === 1'b1 && accept_at < 0) accept_at = cyc;
      n_checks++;
      if ({rstb, stable, rise, fall} !== {m_rstb, m_stable, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL after_reset cyc=%0d: got %h want %h", cyc,
                 {rstb, stable, rise, fall}, {m_rstb, m_stable, m_rise, m_fall});
      end
    end
    n_checks++;
    if (accept_at != DT * P) begin
      n_fail++;
      $display("FAIL count_restart: got accept at edge %0d want %0d", accept_at, DT * P);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_power_on();
    test_lock_loss();
    test_press();
    test_bounce();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
